// File: rtl/pipe_sequencer_if.sv
// Handshake bundle between the pipeline sequencer and its stimulus/consumer side.
// Carries the instruction-register views, the branch and start inputs, and the stage enables and counters.
interface pipe_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [7:0]       ir2;
  logic [7:0]       ir3;
  logic [7:0]       ir4;
  logic             branch_taken;
  logic             pc_load;
  logic             pc_sel_br;
  logic             ir1_load;
  logic             ir1_nop;
  logic             ir2_load;
  logic             ir2_nop;
  logic             ir3_load;
  logic             ir3_nop;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output start, ir2, ir3, ir4, branch_taken,
    input  pc_load, pc_sel_br, ir1_load, ir1_nop, ir2_load, ir2_nop,
           ir3_load, ir3_nop, halted, cycle_count, stall_count
  );

  modport slave (
    input  start, ir2, ir3, ir4, branch_taken,
    output pc_load, pc_sel_br, ir1_load, ir1_nop, ir2_load, ir2_nop,
           ir3_load, ir3_nop, halted, cycle_count, stall_count
  );
endinterface

// File: rtl/pipe_sequencer.sv
// 4-stage pipeline sequencer: PC/IR enables, RAW-hazard bubbles, branch flush, STOP drain/halt,
// and saturating cycle/stall counters.
module pipe_sequencer #(
  parameter int CNT_W  = 16,
  parameter int NOP_OP = 10
) (
  input  logic             i_clock,
  input  logic             i_reset,
  pipe_sequencer_if.slave  io_seq
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

  localparam logic [3:0]       OP_LOAD   = 4'd0;
  localparam logic [3:0]       OP_STOP   = 4'd1;
  localparam logic [3:0]       OP_STORE  = 4'd2;
  localparam logic [3:0]       OP_ADD    = 4'd4;
  localparam logic [3:0]       OP_SUB    = 4'd6;
  localparam logic [3:0]       OP_NAND   = 4'd8;
  localparam logic [3:0]       OP_BUBBLE = 4'(NOP_OP);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_stall_count;
  logic [2:0]       w_dest3;
  logic [2:0]       w_dest4;
  logic             w_hazard;
  logic             w_stop2;
  logic             w_stop4;
  logic             w_stall;
  logic             w_pc_load;
  logic             w_pc_sel_br;
  logic             w_ir1_load;
  logic             w_ir1_nop;
  logic             w_ir2_load;
  logic             w_ir2_nop;
  logic             w_ir3_load;
  logic             w_ir3_nop;
  logic             w_halted;
  logic             w_unused;

  // {valid, register} written by an instruction in EX or WB
  function automatic logic [2:0] f_dest(input logic [3:0] op, input logic [1:0] rd);
    if (op == OP_ADD || op == OP_SUB || op == OP_NAND || op == OP_LOAD || op[2:0] == 3'd3)
      return {1'b1, rd};
    else if (op[2:0] == 3'd7)
      return 3'b101;
    else
      return 3'b000;
  endfunction

  function automatic logic f_reads(input logic [7:0] ir, input logic [2:0] dest);
    case (ir[3:0])
      OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_NAND:
        return dest[2] && (ir[7:6] == dest[1:0] || ir[5:4] == dest[1:0]);
      OP_BUBBLE, OP_STOP:
        return 1'b0;
      default: begin
        if (ir[2:0] == 3'd3)      return dest[2] && (ir[7:6] == dest[1:0]);
        else if (ir[2:0] == 3'd7) return dest[2] && (dest[1:0] == 2'd1);
        else                      return 1'b0;
      end
    endcase
  endfunction

  assign w_dest3  = f_dest(io_seq.ir3[3:0], io_seq.ir3[7:6]);
  assign w_dest4  = f_dest(io_seq.ir4[3:0], io_seq.ir4[7:6]);
  assign w_hazard = f_reads(io_seq.ir2, w_dest3) | f_reads(io_seq.ir2, w_dest4);
  assign w_stop2  = (io_seq.ir2[3:0] == OP_STOP);
  assign w_stop4  = (io_seq.ir4[3:0] == OP_STOP);
  assign w_unused = ^{io_seq.ir3[5:4], io_seq.ir4[5:4]};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_cycle_count <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_RUN || r_state == S_DRAIN) && r_cycle_count != CNT_MAX)
        r_cycle_count <= r_cycle_count + CNT_ONE;
      if (w_stall && r_stall_count != CNT_MAX)
        r_stall_count <= r_stall_count + CNT_ONE;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_stall     = 1'b0;
    w_pc_load   = 1'b0;
    w_pc_sel_br = 1'b0;
    w_ir1_load  = 1'b0;
    w_ir1_nop   = 1'b0;
    w_ir2_load  = 1'b0;
    w_ir2_nop   = 1'b0;
    w_ir3_load  = 1'b0;
    w_ir3_nop   = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_seq.start) w_next = S_RUN;
      end
      S_RUN, S_DRAIN: begin
        // A taken branch is older than anything in IF/RF, so it wins over hazards and STOP
        if (io_seq.branch_taken) begin
          w_pc_load   = 1'b1;
          w_pc_sel_br = 1'b1;
          w_ir1_load  = 1'b1;
          w_ir1_nop   = 1'b1;
          w_ir2_load  = 1'b1;
          w_ir2_nop   = 1'b1;
          w_ir3_load  = 1'b1;
          w_next      = S_RUN;
        end else if (r_state == S_DRAIN) begin
          w_ir1_load = 1'b1;
          w_ir1_nop  = 1'b1;
          w_ir2_load = 1'b1;
          w_ir2_nop  = 1'b1;
          w_ir3_load = 1'b1;
          w_ir3_nop  = !w_stop2;
          if (w_stop4) w_next = S_HALT;
        end else if (w_hazard) begin
          w_ir3_load = 1'b1;
          w_ir3_nop  = 1'b1;
          w_stall    = 1'b1;
        end else if (w_stop2) begin
          w_ir1_load = 1'b1;
          w_ir1_nop  = 1'b1;
          w_ir2_load = 1'b1;
          w_ir2_nop  = 1'b1;
          w_ir3_load = 1'b1;
          w_next     = S_DRAIN;
        end else begin
          w_pc_load  = 1'b1;
          w_ir1_load = 1'b1;
          w_ir2_load = 1'b1;
          w_ir3_load = 1'b1;
        end
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign io_seq.pc_load     = w_pc_load;
  assign io_seq.pc_sel_br   = w_pc_sel_br;
  assign io_seq.ir1_load    = w_ir1_load;
  assign io_seq.ir1_nop     = w_ir1_nop;
  assign io_seq.ir2_load    = w_ir2_load;
  assign io_seq.ir2_nop     = w_ir2_nop;
  assign io_seq.ir3_load    = w_ir3_load;
  assign io_seq.ir3_nop     = w_ir3_nop;
  assign io_seq.halted      = w_halted;
  assign io_seq.cycle_count = r_cycle_count;
  assign io_seq.stall_count = r_stall_count;
endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: hazard/branch vector table plus STOP drain, halt, reset and
// counter-saturation sequences.
module tb_pipe_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic rst4;
  always #5 clk = ~clk;

  pipe_sequencer_if #(.CNT_W(16)) sq();
  pipe_sequencer_if #(.CNT_W(4))  sq4();

  pipe_sequencer #(.CNT_W(16), .NOP_OP(10)) dut (
    .i_clock(clk), .i_reset(rst), .io_seq(sq)
  );
  pipe_sequencer #(.CNT_W(4), .NOP_OP(10)) dut4 (
    .i_clock(clk), .i_reset(rst4), .io_seq(sq4)
  );

  // {pc_load, pc_sel_br, ir1_load, ir1_nop, ir2_load, ir2_nop, ir3_load, ir3_nop}
  localparam logic [7:0] E_OFF   = 8'b0000_0000;
  localparam logic [7:0] E_NORM  = 8'b1010_1010;
  localparam logic [7:0] E_STALL = 8'b0000_0011;
  localparam logic [7:0] E_BR    = 8'b1111_1110;
  localparam logic [7:0] E_STOP  = 8'b0011_1110;
  localparam logic [7:0] E_DRAIN = 8'b0011_1111;

  typedef struct {
    logic [7:0] ir2;
    logic [7:0] ir3;
    logic [7:0] ir4;
    logic       br;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[12];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] en_vec();
    return {sq.pc_load, sq.pc_sel_br, sq.ir1_load, sq.ir1_nop,
            sq.ir2_load, sq.ir2_nop, sq.ir3_load, sq.ir3_nop};
  endfunction

  function automatic logic [7:0] en_vec4();
    return {sq4.pc_load, sq4.pc_sel_br, sq4.ir1_load, sq4.ir1_nop,
            sq4.ir2_load, sq4.ir2_nop, sq4.ir3_load, sq4.ir3_nop};
  endfunction

  task automatic drive(input logic [7:0] i2, input logic [7:0] i3, input logic [7:0] i4,
                       input logic br);
    sq.ir2 = i2; sq.ir3 = i3; sq.ir4 = i4; sq.branch_taken = br;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    // ir encoding: {rd[7:6], rs[5:4], op[3:0]}
    vt[0]  = '{8'h14, 8'hB4, 8'h0A, 1'b0, E_NORM};   // add r0,r1 vs add->r2
    vt[1]  = '{8'h64, 8'h07, 8'h0A, 1'b0, E_STALL};  // add r1,r2 vs ori in EX
    vt[2]  = '{8'h64, 8'h0A, 8'h07, 1'b0, E_STALL};  // add r1,r2 vs ori in WB
    vt[3]  = '{8'h64, 8'h07, 8'h0A, 1'b1, E_BR};     // branch overrides hazard
    vt[4]  = '{8'h32, 8'hC0, 8'h0A, 1'b0, E_STALL};  // store reads r3, load->r3
    vt[5]  = '{8'h32, 8'hC2, 8'hC5, 1'b0, E_NORM};   // store/bz write nothing
    vt[6]  = '{8'h43, 8'h06, 8'h0A, 1'b0, E_NORM};   // shift ignores rs field
    vt[7]  = '{8'h43, 8'h0A, 8'h48, 1'b0, E_STALL};  // shift r1 vs nand->r1 in WB
    vt[8]  = '{8'h07, 8'h4B, 8'h0A, 1'b0, E_STALL};  // ori reads r1, shift(11)->r1
    vt[9]  = '{8'h55, 8'h44, 8'h0A, 1'b0, E_NORM};   // bz reads nothing
    vt[10] = '{8'h0F, 8'h00, 8'h0A, 1'b0, E_NORM};   // ori(15) r1 vs load->r0
    vt[11] = '{8'h0A, 8'h0A, 8'h0A, 1'b1, E_BR};

    rst = 1'b1; rst4 = 1'b1;
    sq.start = 1'b0; sq4.start = 1'b0;
    drive(8'h0A, 8'h0A, 8'h0A, 1'b0);
    sq4.ir2 = 8'h0A; sq4.ir3 = 8'h0A; sq4.ir4 = 8'h0A; sq4.branch_taken = 1'b0;
    step(); step();
    check("reset_en", en_vec(), E_OFF);
    check("reset_halted", sq.halted, 0);
    check("reset_cycles", sq.cycle_count, 0);
    check("reset_stalls", sq.stall_count, 0);

    rst = 1'b0;
    drive(8'h64, 8'h07, 8'h0A, 1'b1);
    @(negedge clk);
    check("idle_en", en_vec(), E_OFF);
    step();
    check("idle_cycles", sq.cycle_count, 0);

    sq.start = 1'b1; step(); sq.start = 1'b0;
    check("run_entry_cycles", sq.cycle_count, 0);

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].ir2, vt[i].ir3, vt[i].ir4, vt[i].br);
      @(negedge clk);
      check($sformatf("vec%0d_en", i), en_vec(), vt[i].exp);
      step();
    end
    check("vec_cycles", sq.cycle_count, 12);
    check("vec_stalls", sq.stall_count, 5);

    drive(8'h14, 8'hB4, 8'h0A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("indep%0d_en", i), en_vec(), E_NORM);
      step();
    end
    check("indep_cycles", sq.cycle_count, 16);
    check("indep_stalls", sq.stall_count, 5);

    drive(8'h01, 8'h0A, 8'h0A, 1'b0);
    @(negedge clk); check("stop_ir2_en", en_vec(), E_STOP); step();
    drive(8'h0A, 8'h01, 8'h0A, 1'b0);
    @(negedge clk); check("drain1_en", en_vec(), E_DRAIN);
    check("drain1_halted", sq.halted, 0); step();
    drive(8'h0A, 8'h0A, 8'h01, 1'b0);
    @(negedge clk); check("drain2_en", en_vec(), E_DRAIN); step();
    check("halt_halted", sq.halted, 1);
    check("halt_en", en_vec(), E_OFF);
    check("halt_cycles", sq.cycle_count, 19);

    sq.start = 1'b1; drive(8'h14, 8'hB4, 8'h0A, 1'b0); step(); sq.start = 1'b0;
    step(); step();
    check("halt_sticky", sq.halted, 1);
    check("halt_sticky_en", en_vec(), E_OFF);
    check("halt_frozen_cycles", sq.cycle_count, 19);

    rst = 1'b1; step(); rst = 1'b0;
    check("rerst_cycles", sq.cycle_count, 0);
    sq.start = 1'b1; step(); sq.start = 1'b0;
    drive(8'h01, 8'h0A, 8'h0A, 1'b1);
    @(negedge clk); check("br_stop_en", en_vec(), E_BR); step();
    drive(8'h0A, 8'h0A, 8'h0A, 1'b0);
    @(negedge clk); check("br_stop_run_en", en_vec(), E_NORM); step();
    check("br_stop_halted", sq.halted, 0);
    check("br_stop_cycles", sq.cycle_count, 2);

    drive(8'h01, 8'h0A, 8'h0A, 1'b0); step();
    drive(8'h0A, 8'h01, 8'h0A, 1'b1);
    @(negedge clk); check("drain_br_en", en_vec(), E_BR); step();
    drive(8'h14, 8'hB4, 8'h0A, 1'b0);
    @(negedge clk); check("drain_br_resume_en", en_vec(), E_NORM); step();

    drive(8'h01, 8'h0A, 8'h0A, 1'b0); step();
    drive(8'h0A, 8'h01, 8'h0A, 1'b0);
    @(negedge clk); check("pre_rst_drain_en", en_vec(), E_DRAIN);
    check("pre_rst_cycles", sq.cycle_count, 6);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_en", en_vec(), E_OFF);
    check("mid_rst_cycles", sq.cycle_count, 0);
    check("mid_rst_stalls", sq.stall_count, 0);
    step(); rst = 1'b0;

    rst4 = 1'b0;
    sq4.ir2 = 8'h64; sq4.ir3 = 8'h07; sq4.ir4 = 8'h0A;
    sq4.start = 1'b1; step(); sq4.start = 1'b0;
    repeat (14) step();
    check("sat_cycles_14", sq4.cycle_count, 14);
    check("sat_stalls_14", sq4.stall_count, 14);
    repeat (6) step();
    check("sat_cycles_max", sq4.cycle_count, 15);
    check("sat_stalls_max", sq4.stall_count, 15);
    check("sat_en", en_vec4(), E_STALL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
